mem_arbiter: RTL and testbench

//  Shares one single-port unified memory between the core's instruction-fetch port (IF) and its load/store port (DM).

---
 rtl/mem_arbiter_if.sv | 41 ++++
 rtl/mem_arbiter.sv | 102 ++++++++++
 tb/tb_mem_arbiter.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core ports, the arbiter and the memory macro.
// Signal directions in the names are as seen from the arbiter.
interface mem_arbiter_if #(
    parameter int AW = 32
);
    logic          if_req_i;
    logic [AW-1:0] if_addr_i;
    logic          if_gnt_o;
    logic          if_rvalid_o;
    logic [31:0]   if_rdata_o;
    logic          dm_req_i;
    logic          dm_we_i;
    logic [AW-1:0] dm_addr_i;
    logic [31:0]   dm_wdata_i;
    logic          dm_gnt_o;
    logic          dm_rvalid_o;
    logic [31:0]   dm_rdata_o;
    logic          mem_req_o;
    logic          mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [31:0]   mem_wdata_o;
    logic [31:0]   mem_rdata_i;

    modport slave (
        input  if_req_i, if_addr_i,
        output if_gnt_o, if_rvalid_o, if_rdata_o,
        input  dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        output dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i
    );

    modport master (
        output if_req_i, if_addr_i,
        input  if_gnt_o, if_rvalid_o, if_rdata_o,
        output dm_req_i, dm_we_i, dm_addr_i, dm_wdata_i,
        input  dm_gnt_o, dm_rvalid_o, dm_rdata_o,
        input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for fetch (IF) and load/store (DM).
// DM wins ties unless IF has waited MAX_STARVE DM grants.
module mem_arbiter #(
    parameter int AW         = 32,
    parameter int MEM_LAT    = 1,
    parameter int MAX_STARVE = 4
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    mem_arbiter_if.slave   bus
);
    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [1:0]    LAT_INIT = 2'(MEM_LAT - 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    typedef enum logic {IDLE, WAIT} state_e;

    state_e        state_q;
    logic          owner_q;
    logic          we_q;
    logic [1:0]    lat_q;
    logic [SW-1:0] starve_q, starve_d;

    logic resp, can_grant, force_if;
    logic gnt_if, gnt_dm, gnt_any;

    // Arbitration and response decode from registered state and requests
    always_comb begin
        resp      = (state_q == WAIT) && (lat_q == 2'd0);
        can_grant = (state_q == IDLE) || resp;
        force_if  = bus.if_req_i && (starve_q == STARVE_MAX);
        gnt_dm    = rst_ni && can_grant && bus.dm_req_i && !force_if;
        gnt_if    = rst_ni && can_grant && bus.if_req_i && !gnt_dm;
        gnt_any   = gnt_dm || gnt_if;
    end

    // Drive the core-side handshakes and the memory strobe
    always_comb begin
        bus.if_gnt_o    = gnt_if;
        bus.dm_gnt_o    = gnt_dm;
        bus.mem_req_o   = gnt_any;
        bus.mem_we_o    = 1'b0;
        bus.mem_addr_o  = '0;
        bus.mem_wdata_o = '0;
        if (gnt_dm) begin
            bus.mem_we_o    = bus.dm_we_i;
            bus.mem_addr_o  = bus.dm_addr_i;
            bus.mem_wdata_o = bus.dm_wdata_i;
        end else if (gnt_if) begin
            bus.mem_addr_o  = bus.if_addr_i;
        end
        bus.if_rvalid_o = rst_ni && resp && !owner_q;
        bus.dm_rvalid_o = rst_ni && resp && owner_q;
        bus.if_rdata_o  = bus.if_rvalid_o ? bus.mem_rdata_i : 32'h0;
        bus.dm_rdata_o  = (bus.dm_rvalid_o && !we_q) ? bus.mem_rdata_i : 32'h0;
    end

    // Starvation counter: counts DM grants taken while IF is waiting
    always_comb begin
        starve_d = starve_q;
        if (!bus.if_req_i || gnt_if) begin
            starve_d = '0;
        end else if (gnt_dm && (starve_q != STARVE_MAX)) begin
            starve_d = starve_q + SW'(1);
        end
    end

    // Access FSM: IDLE until a grant, WAIT counts down memory latency
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            we_q     <= 1'b0;
            lat_q    <= 2'd0;
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
            case (state_q)
                IDLE: begin
                    if (gnt_any) begin
                        owner_q <= gnt_dm;
                        we_q    <= gnt_dm && bus.dm_we_i;
                        lat_q   <= LAT_INIT;
                        state_q <= WAIT;
                    end
                end
                WAIT: begin
                    if (lat_q != 2'd0) begin
                        lat_q <= lat_q - 2'd1;
                    end else if (gnt_any) begin
                        owner_q <= gnt_dm;
                        we_q    <= gnt_dm && bus.dm_we_i;
                        lat_q   <= LAT_INIT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: one instance at MEM_LAT=1,
// one at MEM_LAT=3, each with a small memory model behind it.
module tb_mem_arbiter;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;

    mem_arbiter_if #(.AW(32)) a ();
    mem_arbiter_if #(.AW(32)) b ();

    mem_arbiter #(.AW(32), .MEM_LAT(1), .MAX_STARVE(4)) u_a (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (a)
    );

    mem_arbiter #(.AW(32), .MEM_LAT(3), .MAX_STARVE(4)) u_b (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mem [16];
    logic [31:0] pa;
    logic [31:0] pb1, pb2, pb3;

    always @(posedge clk) begin
        if (a.mem_req_o && a.mem_we_o) mem[a.mem_addr_o[5:2]] <= a.mem_wdata_o;
        pa  <= a.mem_addr_o;
        pb1 <= b.mem_addr_o;
        pb2 <= pb1;
        pb3 <= pb2;
    end

    assign a.mem_rdata_i = mem[pa[5:2]];
    assign b.mem_rdata_i = mem[pb3[5:2]];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    localparam logic [19:0] PAT_DM = 20'b0111_1011_1101_1110_1111;
    localparam logic [16:0] PAT_BG = 17'b1_0010_0010_0100_1001;
    localparam logic [16:0] PAT_BV = 17'b1_0000_0010_0100_1000;

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 16; i++) mem[i] = 32'h1000_0000 + i;
        mem[0] = 32'h0050_0093;
        pa = '0; pb1 = '0; pb2 = '0; pb3 = '0;
        rst_n = 1'b0;
        a.if_req_i = 0; a.if_addr_i = '0;
        a.dm_req_i = 0; a.dm_we_i = 0; a.dm_addr_i = '0; a.dm_wdata_i = '0;
        b.if_req_i = 0; b.if_addr_i = '0;
        b.dm_req_i = 0; b.dm_we_i = 0; b.dm_addr_i = '0; b.dm_wdata_i = '0;

        // Reset: requests present, everything must stay quiet
        cyc();
        a.if_req_i = 1;
        b.dm_req_i = 1; b.dm_addr_i = 32'h40;
        #1;
        chk("rst_a_if_gnt", a.if_gnt_o, 0);
        chk("rst_a_mem_req", a.mem_req_o, 0);
        chk("rst_b_dm_gnt", b.dm_gnt_o, 0);
        chk("rst_b_mem_addr", b.mem_addr_o, 0);
        chk("rst_a_rvalid", a.if_rvalid_o, 0);
        cyc();

        // 1: single fetch
        cyc();
        rst_n = 1;
        a.if_req_i = 1; a.if_addr_i = 32'h0;
        b.dm_req_i = 0; b.dm_addr_i = '0;
        #1;
        chk("t1_if_gnt", a.if_gnt_o, 1);
        chk("t1_dm_gnt", a.dm_gnt_o, 0);
        chk("t1_mem_req", a.mem_req_o, 1);
        chk("t1_mem_addr", a.mem_addr_o, 32'h0);
        cyc();
        a.if_req_i = 0;
        #1;
        chk("t1_if_rvalid", a.if_rvalid_o, 1);
        chk("t1_if_rdata", a.if_rdata_o, 32'h0050_0093);
        chk("t1_mem_req_idle", a.mem_req_o, 0);
        cyc();
        #1;
        chk("t1_rvalid_drop", a.if_rvalid_o, 0);
        chk("t1_rdata_zero", a.if_rdata_o, 0);

        // 2: simultaneous requests, DM first
        cyc();
        a.if_req_i = 1; a.if_addr_i = 32'h4;
        a.dm_req_i = 1; a.dm_we_i = 0; a.dm_addr_i = 32'h20;
        #1;
        chk("t2_dm_gnt", a.dm_gnt_o, 1);
        chk("t2_if_gnt0", a.if_gnt_o, 0);
        chk("t2_mem_addr", a.mem_addr_o, 32'h20);
        cyc();
        a.dm_req_i = 0;
        #1;
        chk("t2_dm_rvalid", a.dm_rvalid_o, 1);
        chk("t2_dm_rdata", a.dm_rdata_o, 32'h1000_0008);
        chk("t2_if_gnt1", a.if_gnt_o, 1);
        chk("t2_mem_addr1", a.mem_addr_o, 32'h4);
        cyc();
        a.if_req_i = 0;
        #1;
        chk("t2_if_rvalid", a.if_rvalid_o, 1);
        chk("t2_if_rdata", a.if_rdata_o, 32'h1000_0001);
        chk("t2_dm_rvalid0", a.dm_rvalid_o, 0);

        // 3: both held, starvation guard forces every fifth grant to IF
        for (int k = 0; k < 20; k++) begin
            cyc();
            a.if_req_i = 1; a.if_addr_i = 32'h8;
            a.dm_req_i = 1; a.dm_we_i = 0; a.dm_addr_i = 32'h24;
            #1;
            chk($sformatf("t3_dm_gnt[%0d]", k), a.dm_gnt_o, PAT_DM[k]);
            chk($sformatf("t3_if_gnt[%0d]", k), a.if_gnt_o, !PAT_DM[k]);
        end
        cyc();
        a.if_req_i = 0; a.dm_req_i = 0;
        #1;
        chk("t3_last_if_rvalid", a.if_rvalid_o, 1);
        chk("t3_no_gnt", a.mem_req_o, 0);

        // 4: store
        cyc();
        a.dm_req_i = 1; a.dm_we_i = 1; a.dm_addr_i = 32'h10;
        a.dm_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("t4_dm_gnt", a.dm_gnt_o, 1);
        chk("t4_mem_we", a.mem_we_o, 1);
        chk("t4_mem_wdata", a.mem_wdata_o, 32'hDEAD_BEEF);
        chk("t4_mem_addr", a.mem_addr_o, 32'h10);
        cyc();
        a.dm_req_i = 0; a.dm_we_i = 0;
        a.if_req_i = 1; a.if_addr_i = 32'h10;
        #1;
        chk("t4_dm_rvalid", a.dm_rvalid_o, 1);
        chk("t4_dm_rdata", a.dm_rdata_o, 0);
        chk("t4_if_we0", a.mem_we_o, 0);
        chk("t4_if_wdata0", a.mem_wdata_o, 0);
        cyc();
        a.if_req_i = 0;
        #1;
        chk("t4_readback", a.if_rdata_o, 32'hDEAD_BEEF);

        // 5/6: MEM_LAT=3 continuous fetch, reset in a response cycle
        for (int k = 0; k < 17; k++) begin
            cyc();
            b.if_req_i = 1; b.if_addr_i = 32'h8;
            rst_n = (k != 12);
            #1;
            chk($sformatf("t5_gnt[%0d]", k), b.if_gnt_o, PAT_BG[k]);
            chk($sformatf("t5_mreq[%0d]", k), b.mem_req_o, PAT_BG[k]);
            chk($sformatf("t5_rv[%0d]", k), b.if_rvalid_o, PAT_BV[k]);
            chk($sformatf("t5_rd[%0d]", k), b.if_rdata_o,
                PAT_BV[k] ? 32'h1000_0002 : 32'h0);
        end
        cyc();
        b.if_req_i = 0;
        rst_n = 1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
